cmd_queue_sched: RTL and testbench
==================================

# cmd_queue_sched

Buffers 16-bit route commands arriving from `UART_wrapper` in a small FIFO and schedules them, one at a time, to the command processor of the line-following robot. This lets a new route be sent over BLE while the current one is still being driven. It owns the UART capture handshake: it acknowledges `cmd_rdy` with `clr_cmd_rdy`. It presents the head command with a valid/pop handshake and flushes all pending routes on a bumper abort.

## Interface
- `DEPTH`, default 4: number of queued commands; must be a power of two, 2..16.
- `CMD_W`, default 16: command width in bits.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd`  in  CMD_W  command word from `UART_wrapper`.
- `cmd_rdy`  in  1  high while a received command is pending in `UART_wrapper`.
- `clr_cmd_rdy`  out  1  one-cycle acknowledge to `UART_wrapper`.
- `pop`  in  1  consumer has taken the head command (one-cycle pulse).
- `flush`  in  1  abort; discards all queued commands (driven on bumper hit).
- `cmd_out`  out  CMD_W  head command word.
- `cmd_vld`  out  1  `cmd_out` holds a valid queued command.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `ovfl`  out  1  sticky: a command was dropped because the queue was full.
- `drop_cnt`  out  8  dropped-command counter; present only with `CMD_QUEUE_STATS_EN`.

## Operation
- Storage: DEPTH x CMD_W register array. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo DEPTH. `count` is $clog2(DEPTH)+1 bits.
- Intake FSM, two states:
  - IDLE: when `cmd_rdy`=1 is sampled, the command is accepted (or dropped) and the FSM goes to HOLD.
  - HOLD: the FSM waits until `cmd_rdy`=0 is sampled, then returns to IDLE. This guarantees one capture per UART frame even if `cmd_rdy` falls late.
- Accept: on the IDLE edge where `cmd_rdy`=1 and the queue is not full, `cmd` is written at `wr_ptr`, `wr_ptr` increments, and `count` increments.
- Drop: if the queue is full on that edge, the word is discarded. The frame is still acknowledged, `ovfl` is set, and `drop_cnt` saturates at 8'hFF when enabled.
- `clr_cmd_rdy` is registered. It is high for exactly one cycle, the cycle after the IDLE->HOLD transition, for both accept and drop.
- Pop: `pop`=1 with `cmd_vld`=1 advances `rd_ptr` and decrements `count`. `pop` while `cmd_vld`=0 is ignored and raises no error.
- `cmd_out` = array[`rd_ptr`]. `cmd_vld` = !`empty`. `cmd_out` is don't-care when `cmd_vld`=0.
- Simultaneous accept and pop:
  - `count` is unchanged and both pointers advance.
  - When `full`, the accept is judged against the pre-pop `full` and is therefore dropped. Pop frees space only from the next cycle.
- Flush:
  - Has top priority. On the edge where `flush`=1, pointers, `count` and `ovfl` are cleared; a same-cycle pop is ignored.
  - A same-cycle intake is discarded and still acknowledged. It is not counted as a drop.
  - The intake FSM still goes to HOLD if `cmd_rdy`=1.
  - `drop_cnt` is not cleared by flush.
- Command 16'h0000 is queued like any other word; interpreting it is the consumer's job.

## Timing
- Reset values: `clr_cmd_rdy`=0, `cmd_vld`=0, `empty`=1, `full`=0, `ovfl`=0, `drop_cnt`=0; pointers, `count`=0; FSM=IDLE. Array contents are not reset.
- Latency, `cmd_rdy` sampled to `cmd_vld`: `cmd_rdy` sampled at edge N into an empty queue gives `cmd_vld`=1 and `clr_cmd_rdy`=1 during cycle N..N+1.
- Pop latency: the next entry appears on `cmd_out` one cycle after the pop edge.
- Reset asserted mid-operation: all state clears immediately (asynchronous reset), and queued commands are lost.
- Max intake rate is one command per 2 cycles (IDLE, HOLD). The UART rate makes this a non-limit.

## Configuration
- `CMD_QUEUE_STATS_EN` defined:
  - `drop_cnt` port and its 8-bit saturating counter are built.
  - It increments on each full-drop and is cleared only by `rst_n`.
- Not defined:
  - The port and counter are absent.
  - `ovfl` behaviour is identical.

## Test plan
- Reset, then a single `cmd`=16'h00E4 with `cmd_rdy` held high for 3 cycles -> one `clr_cmd_rdy` pulse; `cmd_out`=16'h00E4 and `cmd_vld`=1 the cycle after the sampling edge; `count`=1 (no double capture).
- Push 16'h0001..16'h0004 with DEPTH=4 -> `full`=1. A fifth word 16'h0005 -> acknowledged, not stored, `ovfl`=1, `drop_cnt`=1.
- Pop 4 times -> `cmd_out` sequence 1,2,3,4; then `empty`=1, `cmd_vld`=0. A fifth pop -> no pointer change.
- With `count`=2, accept 16'h00AA in the same cycle as `pop` -> `count` stays 2; 16'h00AA appears after the remaining entry. Repeat at `full` -> word dropped, `count`=3.
- With `count`=3 and `ovfl`=1, assert `flush` together with `cmd_rdy` and `pop` -> next cycle `empty`=1, `ovfl`=0, one `clr_cmd_rdy` pulse, `drop_cnt` unchanged.
- Assert `rst_n`=0 asynchronously with `count`=2 -> outputs reach reset values without a clock edge; the next command is accepted normally.

Source files
------------

// File: rtl/cmd_queue_sched.sv
// cmd_queue_sched
//   Small command FIFO between UART_wrapper and the robot command processor.
//   Captures one command per UART frame (acknowledged with clr_cmd_rdy),
//   presents the oldest queued command with a valid/pop handshake, and
//   discards everything pending on flush (bumper abort).
//
//   Parameters
//     DEPTH        queue depth, power of two, 2..16
//     CMD_W        command width
//   Ports
//     clk, rst_n   clock, async active-low reset
//     cmd          command word from UART_wrapper
//     cmd_rdy      a received command is pending in UART_wrapper
//     clr_cmd_rdy  registered one-cycle acknowledge per captured frame
//     pop          consumer has taken the head command
//     flush        discard all queued commands
//     cmd_out      head command (don't-care while cmd_vld=0)
//     cmd_vld      queue not empty
//     full, empty  occupancy flags
//     ovfl         sticky: a command was dropped because the queue was full
//     drop_cnt     saturating drop counter (only with CMD_QUEUE_STATS_EN)
//
//   Build option: define CMD_QUEUE_STATS_EN to build drop_cnt.
module cmd_queue_sched #(
   parameter int DEPTH = 4,
   parameter int CMD_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CMD_W-1:0] cmd,
   input  logic             cmd_rdy,
   output logic             clr_cmd_rdy,
   input  logic             pop,
   input  logic             flush,
   output logic [CMD_W-1:0] cmd_out,
   output logic             cmd_vld,
   output logic             full,
   output logic             empty,
   output logic             ovfl
`ifdef CMD_QUEUE_STATS_EN
   ,
   output logic [7:0]       drop_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               ovfl_q;
   logic               clr_q;
   logic [CMD_W-1:0]   mem [DEPTH];

   logic               take;    // frame captured this edge (accepted, dropped or flushed)
   logic               acc;
   logic               drop;
   logic               do_pop;

   // ---------------------------------------------------------------
   // Intake FSM: IDLE captures on cmd_rdy, HOLD waits for cmd_rdy to
   // fall so a slow-clearing cmd_rdy cannot produce a second capture.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_rdy) begin
               take    = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!cmd_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Full is judged before any same-cycle pop; flush swallows the intake
   // without counting it as a drop.
   assign acc    = take && !flush && !full;
   assign drop   = take && !flush &&  full;
   assign do_pop = pop && cmd_vld && !flush;

   // ---------------------------------------------------------------
   // Pointers, occupancy, sticky overflow, acknowledge
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovfl_q <= 1'b0;
         clr_q  <= 1'b0;
      end else begin
         clr_q <= take;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovfl_q <= 1'b0;
         end else begin
            if (acc)    wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({acc, do_pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
            if (drop) ovfl_q <= 1'b1;
         end
      end
   end

   // Storage is not reset; cmd_vld masks stale contents.
   always_ff @(posedge clk) begin
      if (acc) mem[wr_ptr] <= cmd;
   end

`ifdef CMD_QUEUE_STATS_EN
   // Saturating drop counter; survives flush, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        drop_cnt <= 8'h00;
      else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
   end
`endif

   assign empty       = (count == '0);
   assign full        = (count == CNT_W'(DEPTH));
   assign cmd_vld     = !empty;
   assign cmd_out     = mem[rd_ptr];
   assign ovfl        = ovfl_q;
   assign clr_cmd_rdy = clr_q;

endmodule

// File: tb/tb_cmd_queue_sched.sv
// tb_cmd_queue_sched
//   Table of single-edge vectors with hand-derived expectations covering the
//   directed scenarios, a hand-written asynchronous-reset sequence, then a
//   random phase checked against a queue scoreboard.
module tb_cmd_queue_sched;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd;
   logic        cmd_rdy, pop, flush;
   logic        clr_cmd_rdy, cmd_vld, full, empty, ovfl;
   logic [15:0] cmd_out;
`ifdef CMD_QUEUE_STATS_EN
   logic [7:0]  drop_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cmd_queue_sched #(.DEPTH(DEPTH), .CMD_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cmd),
      .cmd_rdy     (cmd_rdy),
      .clr_cmd_rdy (clr_cmd_rdy),
      .pop         (pop),
      .flush       (flush),
      .cmd_out     (cmd_out),
      .cmd_vld     (cmd_vld),
      .full        (full),
      .empty       (empty),
      .ovfl        (ovfl)
`ifdef CMD_QUEUE_STATS_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic [15:0] cmd;
      logic        pop;
      logic        flush;
      logic        e_clr;
      logic        e_vld;
      logic        e_full;
      logic        e_ovfl;
      logic [15:0] e_out;
      logic [7:0]  e_drop;
   } vec_t;

   vec_t tv[$];

   task automatic add(input logic r, input logic [15:0] c, input logic p, input logic f,
                      input logic ec, input logic ev, input logic efu, input logic eo,
                      input logic [15:0] eout, input logic [7:0] ed);
      vec_t v;
      v.rdy = r; v.cmd = c; v.pop = p; v.flush = f;
      v.e_clr = ec; v.e_vld = ev; v.e_full = efu; v.e_ovfl = eo;
      v.e_out = eout; v.e_drop = ed;
      tv.push_back(v);
   endtask

   // scoreboard model state
   logic [15:0] mq[$];
   logic        m_hold, m_ovfl, m_clr;
`ifdef CMD_QUEUE_STATS_EN
   int          m_drop;
`endif

   task automatic model_edge(input logic r, input logic [15:0] c, input logic p, input logic f);
      bit tk;
      tk    = !m_hold && r;
      m_clr = tk;
      if (f) begin
         mq.delete();
         m_ovfl = 1'b0;
      end else begin
         bit was_full;
         was_full = (mq.size() == DEPTH);
         if (p && mq.size() > 0) void'(mq.pop_front());
         if (tk && !was_full) mq.push_back(c);
         if (tk && was_full) begin
            m_ovfl = 1'b1;
`ifdef CMD_QUEUE_STATS_EN
            if (m_drop < 255) m_drop++;
`endif
         end
      end
      if (!m_hold && r)      m_hold = 1'b1;
      else if (m_hold && !r) m_hold = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      m_hold = 1'b0; m_ovfl = 1'b0; m_clr = 1'b0;
`ifdef CMD_QUEUE_STATS_EN
      m_drop = 0;
`endif
   endtask

   initial begin
      rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; pop = 1'b0; flush = 1'b0;
      repeat (2) @(negedge clk);

      // reset state
      chk("rst_clr",   clr_cmd_rdy, 0);
      chk("rst_vld",   cmd_vld, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full",  full, 0);
      chk("rst_ovfl",  ovfl, 0);
`ifdef CMD_QUEUE_STATS_EN
      chk("rst_drop",  drop_cnt, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      //   rdy  cmd      pop  fl  clr vld full ovf out      drop
      // single command, cmd_rdy held 3 cycles -> one capture
      add(1, 16'h00E4, 0, 0,  1, 1, 0, 0, 16'h00E4, 0);
      add(1, 16'h00E4, 0, 0,  0, 1, 0, 0, 16'h00E4, 0);
      add(1, 16'h00E4, 0, 0,  0, 1, 0, 0, 16'h00E4, 0);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h00E4, 0);
      add(0, 16'h0000, 1, 0,  0, 0, 0, 0, 16'h0000, 0);
      // fill 1..4, then drop 5
      add(1, 16'h0001, 0, 0,  1, 1, 0, 0, 16'h0001, 0);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0001, 0);
      add(1, 16'h0002, 0, 0,  1, 1, 0, 0, 16'h0001, 0);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0001, 0);
      add(1, 16'h0003, 0, 0,  1, 1, 0, 0, 16'h0001, 0);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 0, 16'h0001, 0);
      add(1, 16'h0004, 0, 0,  1, 1, 1, 0, 16'h0001, 0);
      add(0, 16'h0000, 0, 0,  0, 1, 1, 0, 16'h0001, 0);
      add(1, 16'h0005, 0, 0,  1, 1, 1, 1, 16'h0001, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 1, 1, 16'h0001, 1);
      // drain 4, plus one ignored pop
      add(0, 16'h0000, 1, 0,  0, 1, 0, 1, 16'h0002, 1);
      add(0, 16'h0000, 1, 0,  0, 1, 0, 1, 16'h0003, 1);
      add(0, 16'h0000, 1, 0,  0, 1, 0, 1, 16'h0004, 1);
      add(0, 16'h0000, 1, 0,  0, 0, 0, 1, 16'h0000, 1);
      add(0, 16'h0000, 1, 0,  0, 0, 0, 1, 16'h0000, 1);
      // count=2, accept 00AA with pop
      add(1, 16'h0010, 0, 0,  1, 1, 0, 1, 16'h0010, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0010, 1);
      add(1, 16'h0011, 0, 0,  1, 1, 0, 1, 16'h0010, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0010, 1);
      add(1, 16'h00AA, 1, 0,  1, 1, 0, 1, 16'h0011, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0011, 1);
      add(0, 16'h0000, 1, 0,  0, 1, 0, 1, 16'h00AA, 1);
      add(0, 16'h0000, 1, 0,  0, 0, 0, 1, 16'h0000, 1);
      // full, accept with pop -> dropped, count=3
      add(1, 16'h0021, 0, 0,  1, 1, 0, 1, 16'h0021, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0021, 1);
      add(1, 16'h0022, 0, 0,  1, 1, 0, 1, 16'h0021, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0021, 1);
      add(1, 16'h0023, 0, 0,  1, 1, 0, 1, 16'h0021, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0021, 1);
      add(1, 16'h0024, 0, 0,  1, 1, 1, 1, 16'h0021, 1);
      add(0, 16'h0000, 0, 0,  0, 1, 1, 1, 16'h0021, 1);
      add(1, 16'h00BB, 1, 0,  1, 1, 0, 1, 16'h0022, 2);
      add(0, 16'h0000, 0, 0,  0, 1, 0, 1, 16'h0022, 2);
      // flush with cmd_rdy and pop, count=3, ovfl=1
      add(1, 16'h00CC, 1, 1,  1, 0, 0, 0, 16'h0000, 2);
      add(1, 16'h00CC, 0, 0,  0, 0, 0, 0, 16'h0000, 2);
      add(0, 16'h0000, 0, 0,  0, 0, 0, 0, 16'h0000, 2);

      for (int i = 0; i < tv.size(); i++) begin
         cmd = tv[i].cmd; cmd_rdy = tv[i].rdy; pop = tv[i].pop; flush = tv[i].flush;
         @(negedge clk);
         chk($sformatf("v%0d_clr", i),   clr_cmd_rdy, tv[i].e_clr);
         chk($sformatf("v%0d_vld", i),   cmd_vld,     tv[i].e_vld);
         chk($sformatf("v%0d_empty", i), empty,       !tv[i].e_vld);
         chk($sformatf("v%0d_full", i),  full,        tv[i].e_full);
         chk($sformatf("v%0d_ovfl", i),  ovfl,        tv[i].e_ovfl);
         if (tv[i].e_vld) chk($sformatf("v%0d_out", i), cmd_out, tv[i].e_out);
`ifdef CMD_QUEUE_STATS_EN
         chk($sformatf("v%0d_drop", i), drop_cnt, tv[i].e_drop);
`endif
      end

      // asynchronous reset with two commands queued and clr_cmd_rdy high
      cmd = 16'h0031; cmd_rdy = 1'b1; pop = 1'b0; flush = 1'b0;
      @(negedge clk);
      cmd_rdy = 1'b0;
      @(negedge clk);
      cmd = 16'h0032; cmd_rdy = 1'b1;
      @(negedge clk);
      chk("ar_pre_clr", clr_cmd_rdy, 1);
      chk("ar_pre_out", cmd_out, 16'h0031);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_clr",   clr_cmd_rdy, 0);
      chk("ar_vld",   cmd_vld, 0);
      chk("ar_empty", empty, 1);
      chk("ar_full",  full, 0);
      chk("ar_ovfl",  ovfl, 0);
`ifdef CMD_QUEUE_STATS_EN
      chk("ar_drop",  drop_cnt, 0);
`endif
      cmd_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd = 16'h0077; cmd_rdy = 1'b1;
      @(negedge clk);
      chk("ar_next_clr", clr_cmd_rdy, 1);
      chk("ar_next_vld", cmd_vld, 1);
      chk("ar_next_out", cmd_out, 16'h0077);
      cmd_rdy = 1'b0; pop = 1'b1;
      @(negedge clk);
      chk("ar_next_empty", empty, 1);
      pop = 1'b0;

      // random phase against the scoreboard
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 600; n++) begin
         logic r, p, f;
         logic [15:0] c;
         r = ($urandom_range(0, 2) != 0);
         p = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 39) == 0);
         c = 16'($urandom);
         cmd = c; cmd_rdy = r; pop = p; flush = f;
         model_edge(r, c, p, f);
         @(negedge clk);
         chk("sb_clr",   clr_cmd_rdy, m_clr);
         chk("sb_vld",   cmd_vld, mq.size() != 0);
         chk("sb_empty", empty, mq.size() == 0);
         chk("sb_full",  full, mq.size() == DEPTH);
         chk("sb_ovfl",  ovfl, m_ovfl);
         if (mq.size() != 0) chk("sb_out", cmd_out, mq[0]);
`ifdef CMD_QUEUE_STATS_EN
         chk("sb_drop", drop_cnt, m_drop);
`endif
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
